// File: rtl/game_state_regs.sv
// Score/fruit/life register bank for the game FSM, with session high score
// and a bit-serial double-dabble converter feeding the score HUD digits.
module game_state_regs #(
   parameter int unsigned MAX_LIVES = 3
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        restart,
   input  logic        Load_S,
   input  logic [9:0]  score_in,
   input  logic        Load_F,
   input  logic [3:0]  fruits_in,
   input  logic        Load_L,
   input  logic [7:0]  lives_in,
   output logic [9:0]  score_out,
   output logic [3:0]  fruits_out,
   output logic [1:0]  lives_out,
   output logic        all_fruits,
   output logic [9:0]  high_score,
   output logic [15:0] score_bcd,
   output logic        bcd_valid
);

   localparam int unsigned SCORE_W = 10;
   localparam int unsigned BCD_W   = 16;
   localparam int unsigned CNT_W   = 4;
   localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(SCORE_W - 1);
   localparam logic [7:0]       MAX_L8     = 8'(MAX_LIVES);
   localparam logic [1:0]       MAX_L2     = 2'(MAX_LIVES);

   typedef enum logic {S_IDLE, S_CONV} state_t;

   state_t                     r_state, w_state_nxt;
   logic [SCORE_W-1:0]         r_score, r_high, r_shreg;
   logic [3:0]                 r_fruits;
   logic [1:0]                 r_lives;
   logic [BCD_W-1:0]           r_acc, r_bcd;
   logic                       r_valid;
   logic [CNT_W-1:0]           r_cnt;

   logic                       w_done;
   logic [BCD_W-1:0]           w_acc_adj;
   logic [BCD_W+SCORE_W-1:0]   w_shl;
   logic [1:0]                 w_lives_sat;

   // Converter next state; restart beats a new load, which beats completion
   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
      if (restart) begin
         w_state_nxt = S_IDLE;
      end else begin
         if (r_state == S_CONV && r_cnt == LAST_SHIFT) begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         if (Load_S) w_state_nxt = S_CONV;
      end
   end

   // One double-dabble step: add-3 correction, then shift {acc, shreg}
   always_comb begin
      w_acc_adj = r_acc;
      for (int i = 0; i < 4; i++) begin
         if (r_acc[4*i +: 4] >= 4'd5) w_acc_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
      end
      w_shl       = {w_acc_adj, r_shreg} << 1;
      w_lives_sat = (lives_in > MAX_L8) ? MAX_L2 : lives_in[1:0];
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_score  <= '0;
         r_fruits <= '0;
         r_lives  <= '0;
         r_high   <= '0;
         r_bcd    <= '0;
         r_valid  <= 1'b1;
         r_acc    <= '0;
         r_shreg  <= '0;
         r_cnt    <= '0;
      end else if (restart) begin
         r_high   <= (r_score > r_high) ? r_score : r_high;
         r_score  <= '0;
         r_fruits <= '0;
         r_lives  <= '0;
         r_bcd    <= '0;
         r_valid  <= 1'b1;
         r_cnt    <= '0;
      end else begin
         if (w_done) begin
            r_bcd   <= w_shl[BCD_W+SCORE_W-1:SCORE_W];
            r_valid <= 1'b1;
         end
         if (r_state == S_CONV) begin
            r_acc   <= w_shl[BCD_W+SCORE_W-1:SCORE_W];
            r_shreg <= w_shl[SCORE_W-1:0];
            r_cnt   <= r_cnt + CNT_W'(1);
         end
         if (Load_S) begin
            r_score <= score_in;
            r_shreg <= score_in;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
         end
         if (Load_F) r_fruits <= fruits_in;
         if (Load_L) r_lives  <= w_lives_sat;
      end
   end

   assign score_out  = r_score;
   assign fruits_out = r_fruits;
   assign lives_out  = r_lives;
   assign all_fruits = &r_fruits;
   assign high_score = r_high;
   assign score_bcd  = r_bcd;
   assign bcd_valid  = r_valid;

endmodule

// File: tb/tb_game_state_regs.sv
// Bench for game_state_regs: directed scenarios plus random strobes, checked
// every cycle against a decimal-arithmetic reference model.
module tb_game_state_regs;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        restart = 1'b0;
   logic        Load_S = 1'b0;
   logic [9:0]  score_in = '0;
   logic        Load_F = 1'b0;
   logic [3:0]  fruits_in = '0;
   logic        Load_L = 1'b0;
   logic [7:0]  lives_in = '0;
   logic [9:0]  score_out;
   logic [3:0]  fruits_out;
   logic [1:0]  lives_out;
   logic        all_fruits;
   logic [9:0]  high_score;
   logic [15:0] score_bcd;
   logic        bcd_valid;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   int m_score, m_fruits, m_lives, m_high, m_bcd_val, m_conv_val, m_conv_left;
   bit m_valid;

   game_state_regs #(.MAX_LIVES(3)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .restart(restart),
      .Load_S(Load_S), .score_in(score_in),
      .Load_F(Load_F), .fruits_in(fruits_in),
      .Load_L(Load_L), .lives_in(lives_in),
      .score_out(score_out), .fruits_out(fruits_out), .lives_out(lives_out),
      .all_fruits(all_fruits), .high_score(high_score),
      .score_bcd(score_bcd), .bcd_valid(bcd_valid)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      r = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
      return r;
   endfunction

   task automatic model_reset();
      m_score = 0; m_fruits = 0; m_lives = 0; m_high = 0;
      m_bcd_val = 0; m_valid = 1'b1; m_conv_val = 0; m_conv_left = 0;
   endtask

   task automatic model_edge();
      if (restart) begin
         if (m_score > m_high) m_high = m_score;
         m_score = 0; m_fruits = 0; m_lives = 0;
         m_bcd_val = 0; m_valid = 1'b1; m_conv_left = 0;
      end else begin
         if (m_conv_left > 0) begin
            m_conv_left--;
            if (m_conv_left == 0) begin
               m_bcd_val = int'(to_bcd(m_conv_val));
               m_valid   = 1'b1;
            end
         end
         if (Load_S) begin
            m_score = int'(score_in); m_conv_val = int'(score_in);
            m_conv_left = 10; m_valid = 1'b0;
         end
         if (Load_F) m_fruits = int'(fruits_in);
         if (Load_L) m_lives = (int'(lives_in) > 3) ? 3 : int'(lives_in);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".score"},  32'(score_out),  32'(m_score));
      check({tag, ".fruits"}, 32'(fruits_out), 32'(m_fruits));
      check({tag, ".lives"},  32'(lives_out),  32'(m_lives));
      check({tag, ".allf"},   32'(all_fruits), 32'(m_fruits == 15));
      check({tag, ".high"},   32'(high_score), 32'(m_high));
      check({tag, ".bcd"},    32'(score_bcd),  32'(m_bcd_val));
      check({tag, ".valid"},  32'(bcd_valid),  32'(m_valid));
   endtask

   // apply inputs, take one rising edge, update the model, compare
   task automatic cyc(input bit rs, input bit ls, input int si, input bit lf,
                      input int fi, input bit ll, input int li, input string tag);
      restart = rs; Load_S = ls; score_in = 10'(si);
      Load_F = lf; fruits_in = 4'(fi); Load_L = ll; lives_in = 8'(li);
      @(posedge Clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, tag);
   endtask

   initial begin
      model_reset();
      #12;
      check_all("reset");
      @(negedge Clk); Reset_n = 1'b1;
      idle(2, "idle");

      // basic conversions
      cyc(0, 1, 50, 0, 0, 0, 0, "ld50");
      check("ld50.score_now", 32'(score_out), 32'd50);
      idle(9, "conv50");
      check("conv50.pending", 32'(bcd_valid), 32'd0);
      idle(1, "done50");
      check("done50.bcd", 32'(score_bcd), 32'h0050);
      cyc(0, 1, 1023, 0, 0, 0, 0, "ld1023");
      idle(10, "conv1023");
      check("done1023.bcd", 32'(score_bcd), 32'h1023);

      // reload mid-conversion
      cyc(0, 1, 200, 0, 0, 0, 0, "ld200");
      idle(3, "conv200");
      cyc(0, 1, 999, 0, 0, 0, 0, "ld999");
      idle(9, "conv999");
      check("conv999.old", 32'(score_bcd), 32'h1023);
      idle(1, "done999");
      check("done999.bcd", 32'(score_bcd), 32'h0999);

      // back-to-back loads, then load on the completion edge
      cyc(0, 1, 11, 0, 0, 0, 0, "b2b_a");
      cyc(0, 1, 12, 0, 0, 0, 0, "b2b_b");
      idle(10, "b2b");
      check("b2b.bcd", 32'(score_bcd), 32'h0012);
      cyc(0, 1, 345, 0, 0, 0, 0, "col_a");
      idle(9, "col");
      cyc(0, 1, 678, 0, 0, 0, 0, "col_b");
      check("col.oldwritten", 32'(score_bcd), 32'h0345);
      check("col.valid", 32'(bcd_valid), 32'd0);
      idle(10, "col_done");
      check("col_done.bcd", 32'(score_bcd), 32'h0678);

      // lives saturation and fruit mask
      cyc(0, 0, 0, 0, 0, 1, 2, "lives2");
      check("lives2.val", 32'(lives_out), 32'd2);
      cyc(0, 0, 0, 0, 0, 1, 9, "lives9");
      check("lives9.val", 32'(lives_out), 32'd3);
      cyc(0, 0, 0, 0, 0, 1, 260, "lives260");
      cyc(0, 0, 0, 1, 7, 0, 0, "f7");
      check("f7.allf", 32'(all_fruits), 32'd0);
      cyc(0, 0, 0, 1, 15, 0, 0, "f15");
      check("f15.allf", 32'(all_fruits), 32'd1);
      cyc(0, 0, 0, 1, 2, 0, 0, "f2");

      // high score sequence
      cyc(0, 1, 150, 0, 0, 0, 0, "hs150");
      idle(12, "hs150w");
      cyc(1, 0, 0, 0, 0, 0, 0, "rst1");
      check("rst1.high", 32'(high_score), 32'd150);
      check("rst1.score", 32'(score_out), 32'd0);
      cyc(0, 1, 100, 0, 0, 0, 0, "hs100");
      idle(12, "hs100w");
      cyc(1, 0, 0, 0, 0, 0, 0, "rst2");
      check("rst2.high", 32'(high_score), 32'd150);
      cyc(1, 1, 300, 1, 5, 1, 1, "rst_ld");
      check("rst_ld.score", 32'(score_out), 32'd0);
      idle(3, "rst_ld_w");
      check("rst_ld.valid", 32'(bcd_valid), 32'd1);

      // simultaneous loads
      cyc(0, 1, 77, 1, 9, 1, 1, "all3");
      check("all3.score", 32'(score_out), 32'd77);
      idle(11, "all3w");

      // async reset mid-conversion
      cyc(0, 1, 512, 1, 3, 1, 2, "pre_ar");
      idle(4, "pre_arw");
      #2 Reset_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge Clk); Reset_n = 1'b1;
      idle(12, "post_ar");

      // random stimulus
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0),
             int'($urandom_range(0, 1023)), ($urandom_range(0, 3) == 0),
             int'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
             int'($urandom_range(0, 255)), "rand");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/game_state_regs.md
# game_state_regs

Register bank on the far end of the game FSM's load interface: it captures score, fruit and life updates presented with `Load_S`/`Load_F`/`Load_L` and returns them as the `*_from_reg` values the FSM reads back. It also keeps a session high score and runs a sequential binary-to-BCD converter that drives the score HUD digits. It sits between the game FSM and the score/lives overlay renderer.

## Interface
- `MAX_LIVES`, default 3: saturation ceiling for the stored life count; must fit in 2 bits.
- `Clk` in 1: system clock; all state changes on its rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `restart` in 1: synchronous clear request (new game).
- `Load_S` in 1: strobe; capture `score_in`.
- `score_in` in 10: new score value.
- `Load_F` in 1: strobe; capture `fruits_in`.
- `fruits_in` in 4: new fruit-eaten mask, one bit per fruit.
- `Load_L` in 1: strobe; capture `lives_in`.
- `lives_in` in 8: new lives-lost count.
- `score_out` out 10: stored score; feeds `score_from_reg`.
- `fruits_out` out 4: stored fruit mask; feeds `fruits_from_reg`.
- `lives_out` out 2: stored lives-lost count; feeds `lives_from_reg`.
- `all_fruits` out 1: `&fruits_out`, combinational.
- `high_score` out 10: best score seen since reset.
- `score_bcd` out 16: four BCD digits of the last fully converted score; [15:12] is thousands.
- `bcd_valid` out 1: high when `score_bcd` matches `score_out`.

## Operation
- Reset (`Reset_n` low, asynchronous) sets all outputs to 0 except `bcd_valid`, which is 1. The converter returns to IDLE and the bit counter is cleared.
- Priority per edge: `restart` first, then the loads. The three loads are independent; any combination in one cycle is captured together.
- `restart`:
  - `high_score <= max(high_score, score_out)` uses the pre-clear score.
  - `score_out`, `fruits_out` and `lives_out` clear to 0.
  - `score_bcd` clears to 0 and `bcd_valid` is set to 1.
  - Any in-progress conversion is aborted and the converter returns to IDLE.
  - Loads asserted in the same cycle are ignored.
- `Load_S`: `score_out <= score_in`. Starts a conversion of `score_in`.
- `Load_F`: `fruits_out <= fruits_in`. This is a plain overwrite, not an OR.
- `Load_L`: `lives_out <= min(lives_in, MAX_LIVES)[1:0]`. The full 8-bit value is compared before truncation.
- Converter FSM, double-dabble, one bit per cycle:
  - IDLE: on `Load_S`, load the 10-bit shift register with `score_in`, clear the 16-bit BCD accumulator, set the counter to 0, clear `bcd_valid`, and go to CONV.
  - CONV: each cycle, add 3 to every accumulator nibble that is ≥5, then shift {acc, shreg} left by 1 and increment the counter. On the 10th shift, go to IDLE.
  - Completion (same edge as the 10th shift): `score_bcd <=` the final accumulator and `bcd_valid <= 1`.
  - `Load_S` during CONV restarts the conversion from the new value (same actions as from IDLE). The partial result is discarded and `score_bcd` keeps its old value.
- `high_score` changes only on `restart`. `Load_S` never touches it.

## Timing
- Register outputs (`score_out`, `fruits_out`, `lives_out`) update on the same edge the strobe is sampled. The FSM sees the new value in the following cycle.
- `bcd_valid` falls on the `Load_S` edge (edge k).
- `score_bcd` updates and `bcd_valid` rises on edge k+10. Conversion latency is 10 cycles.
- Back-to-back `Load_S` at edges k and k+1: a single conversion of the second value completes at k+11.
- `Load_S` on the completion edge of a running conversion: the old result is still written to `score_bcd`, but `bcd_valid` stays 0 and the new conversion begins. Restart wins over completion.
- Reset asserted mid-conversion: all outputs take their reset values immediately, without waiting for `Clk`.
- `all_fruits` has zero latency relative to `fruits_out`.

## Test plan
- Reset then idle: all outputs are 0 and `bcd_valid`=1. Assert `Reset_n` low mid-conversion: the reset state appears immediately.
- `Load_S` with `score_in`=50 at edge k: `score_out`=50 at k and `bcd_valid`=0 over k..k+9. At k+10, `score_bcd`=16'h0050 and `bcd_valid`=1. Repeat with 1023: `score_bcd`=16'h1023.
- `Load_S` 200 at edge k, then `Load_S` 999 at edge k+4: `score_bcd` stays at its old value until k+14, then becomes 16'h0999. No intermediate 0200 result ever appears.
- `Load_L` with `lives_in`=2: `lives_out`=2. `lives_in`=8'd9: `lives_out`=3. Then `Load_F` 4'b0111 followed by 4'b1111: `all_fruits` goes 0 then 1.
- Sequence: score 150, restart, score 100, restart:
  - After the first restart: `high_score`=150 and `score_out`=0.
  - After the second restart: `high_score` stays 150.
  - `restart` together with `Load_S`=300 in one cycle: `score_out`=0 and no conversion starts.
- `Load_S`, `Load_F` and `Load_L` asserted in the same cycle: all three registers update on that edge.
